// File: rtl/uart_ctrl.sv
// uart_ctrl: 8N1 UART framing controller. Receives a start byte (8'hBB), a header and a
// message body, then hands header/body downstream with a valid/ready handshake. Serializes
// a processed message back to the host with the same framing.
// Optional build macro: UART_DEBUG_EN exposes FSM states and byte counters on debug.
module uart_ctrl #(
  parameter int unsigned MESSAGE_SIZE = 128,
  parameter int unsigned HEADER_SIZE  = 32,
  parameter int unsigned BAUD_RATE    = 3_000_000,
  parameter int unsigned CLK_FREQ     = 100_000_000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    ext_tx_valid_in,
  output logic                    ext_tx_ready_out,
  output logic                    ext_rx_valid_out,
  input  logic                    ext_rx_ready_in,
  input  logic [MESSAGE_SIZE-1:0] tx_encrypted_in,
  input  logic [MESSAGE_SIZE-1:0] tx_decrypted_in,
  input  logic [HEADER_SIZE-1:0]  tx_header_in,
  input  logic [1:0]              tx_mode_in,
  output logic [MESSAGE_SIZE-1:0] rx_message_out,
  output logic [HEADER_SIZE-1:0]  rx_header_out,
  input  logic                    uart_rx_in,
  output logic                    uart_tx_out,
  output logic [13:0]             debug
);

  localparam int unsigned CPB    = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HB     = HEADER_SIZE / 8;
  localparam int unsigned MB     = MESSAGE_SIZE / 8;
  localparam int unsigned TX_SRW = HEADER_SIZE + 2 * MESSAGE_SIZE;

  localparam logic [15:0] CPB_LAST  = 16'(CPB - 1);
  localparam logic [15:0] HALF_LAST = 16'(CPB / 2 - 1);
  localparam logic [7:0]  HB_LAST   = 8'(HB - 1);
  localparam logic [7:0]  MB_LAST   = 8'(MB - 1);
  localparam logic [7:0]  START_BYTE = 8'hBB;

  // RX byte engine states
  localparam logic [1:0] BE_IDLE  = 2'd0;
  localparam logic [1:0] BE_START = 2'd1;
  localparam logic [1:0] BE_DATA  = 2'd2;
  localparam logic [1:0] BE_STOP  = 2'd3;

  // RX packet FSM states
  localparam logic [1:0] RX_HUNT    = 2'd0;
  localparam logic [1:0] RX_HDR     = 2'd1;
  localparam logic [1:0] RX_BODY    = 2'd2;
  localparam logic [1:0] RX_DELIVER = 2'd3;

  // TX FSM states
  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_SEND = 2'd1;

  logic                    r_rx_meta, r_rx_sync, r_rx_prev;
  logic [1:0]              r_be_state;
  logic [15:0]             r_be_cnt;
  logic [2:0]              r_be_bit;
  logic [7:0]              r_be_shift;
  logic                    r_bv, r_ferr;
  logic [7:0]              r_byte;

  logic [1:0]              r_rx_state;
  logic [7:0]              r_rx_cnt;
  logic [HEADER_SIZE-1:0]  r_hdr_sr, r_hdr_out;
  logic [MESSAGE_SIZE-1:0] r_body_sr, r_msg_out;
  logic                    r_rx_pend, r_rx_valid;

  logic [1:0]              r_tx_state;
  logic [15:0]             r_tx_cnt;
  logic [3:0]              r_tx_bit;
  logic [9:0]              r_tx_frame;
  logic [TX_SRW-1:0]       r_tx_sr;
  logic [7:0]              r_tx_idx, r_tx_last;
  logic [MESSAGE_SIZE-1:0] w_first_body;

  // Two-flop synchronizer plus one delay stage for falling-edge detection
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx_in;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // RX byte engine: half-bit start recheck, then one sample per bit period
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_be_state <= BE_IDLE;
      r_be_cnt   <= '0;
      r_be_bit   <= '0;
      r_be_shift <= '0;
      r_bv       <= 1'b0;
      r_ferr     <= 1'b0;
      r_byte     <= '0;
    end else begin
      r_bv   <= 1'b0;
      r_ferr <= 1'b0;
      case (r_be_state)
        BE_IDLE: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_be_state <= BE_START;
            r_be_cnt   <= '0;
          end
        end
        BE_START: begin
          if (r_be_cnt == HALF_LAST) begin
            r_be_cnt   <= '0;
            r_be_bit   <= '0;
            r_be_state <= r_rx_sync ? BE_IDLE : BE_DATA;
          end else begin
            r_be_cnt <= r_be_cnt + 16'd1;
          end
        end
        BE_DATA: begin
          if (r_be_cnt == CPB_LAST) begin
            r_be_cnt   <= '0;
            r_be_shift <= {r_rx_sync, r_be_shift[7:1]};
            r_be_bit   <= r_be_bit + 3'd1;
            if (r_be_bit == 3'd7) r_be_state <= BE_STOP;
          end else begin
            r_be_cnt <= r_be_cnt + 16'd1;
          end
        end
        default: begin
          if (r_be_cnt == CPB_LAST) begin
            r_be_cnt   <= '0;
            r_be_state <= BE_IDLE;
            r_bv       <= r_rx_sync;
            r_ferr     <= !r_rx_sync;
            r_byte     <= r_be_shift;
          end else begin
            r_be_cnt <= r_be_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // RX packet FSM; a pending delivery survives a new start byte arriving in DELIVER
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rx_state <= RX_HUNT;
      r_rx_cnt   <= '0;
      r_hdr_sr   <= '0;
      r_body_sr  <= '0;
      r_hdr_out  <= '0;
      r_msg_out  <= '0;
      r_rx_pend  <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= r_rx_pend && ext_rx_ready_in;
      if (r_rx_pend && ext_rx_ready_in) r_rx_pend <= 1'b0;
      case (r_rx_state)
        RX_HUNT: begin
          if (r_bv && r_byte == START_BYTE) begin
            r_rx_state <= RX_HDR;
            r_rx_cnt   <= '0;
          end
        end
        RX_HDR: begin
          if (r_ferr) begin
            r_rx_state <= RX_HUNT;
          end else if (r_bv) begin
            r_hdr_sr <= {r_byte, r_hdr_sr[HEADER_SIZE-1:8]};
            if (r_rx_cnt == HB_LAST) begin
              r_rx_state <= RX_BODY;
              r_rx_cnt   <= '0;
            end else begin
              r_rx_cnt <= r_rx_cnt + 8'd1;
            end
          end
        end
        RX_BODY: begin
          if (r_ferr) begin
            r_rx_state <= RX_HUNT;
          end else if (r_bv) begin
            r_body_sr <= {r_byte, r_body_sr[MESSAGE_SIZE-1:8]};
            if (r_rx_cnt == MB_LAST) begin
              r_rx_state <= RX_DELIVER;
              r_rx_cnt   <= '0;
              r_hdr_out  <= r_hdr_sr;
              r_msg_out  <= {r_byte, r_body_sr[MESSAGE_SIZE-1:8]};
              r_rx_pend  <= 1'b1;
            end else begin
              r_rx_cnt <= r_rx_cnt + 8'd1;
            end
          end
        end
        default: begin
          if (ext_rx_ready_in) begin
            r_rx_state <= RX_HUNT;
          end else if (r_bv && r_byte == START_BYTE) begin
            r_rx_state <= RX_HDR;
            r_rx_cnt   <= '0;
          end
        end
      endcase
    end
  end

  // Body placed first in the TX shift register depends on mode
  always_comb begin
    w_first_body = tx_encrypted_in;
    if (tx_mode_in == 2'b00) w_first_body = tx_decrypted_in;
  end

  // TX FSM: capture on valid, then stream start byte, header and body(s) back to back
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_frame <= '1;
      r_tx_sr    <= '0;
      r_tx_idx   <= '0;
      r_tx_last  <= '0;
    end else if (r_tx_state == TX_IDLE) begin
      if (ext_tx_valid_in) begin
        r_tx_state <= TX_SEND;
        r_tx_sr    <= {tx_decrypted_in, w_first_body, tx_header_in};
        r_tx_last  <= tx_mode_in[1] ? 8'(HB + 2 * MB) : 8'(HB + MB);
        r_tx_frame <= {1'b1, START_BYTE, 1'b0};
        r_tx_cnt   <= '0;
        r_tx_bit   <= '0;
        r_tx_idx   <= '0;
      end
    end else if (r_tx_cnt == CPB_LAST) begin
      r_tx_cnt <= '0;
      if (r_tx_bit == 4'd9) begin
        if (r_tx_idx == r_tx_last) begin
          r_tx_state <= TX_IDLE;
        end else begin
          r_tx_idx   <= r_tx_idx + 8'd1;
          r_tx_bit   <= '0;
          r_tx_frame <= {1'b1, r_tx_sr[7:0], 1'b0};
          r_tx_sr    <= {8'h00, r_tx_sr[TX_SRW-1:8]};
        end
      end else begin
        r_tx_bit   <= r_tx_bit + 4'd1;
        r_tx_frame <= {1'b1, r_tx_frame[9:1]};
      end
    end else begin
      r_tx_cnt <= r_tx_cnt + 16'd1;
    end
  end

  assign uart_tx_out      = r_tx_frame[0];
  assign ext_tx_ready_out = (r_tx_state == TX_IDLE);
  assign ext_rx_valid_out = r_rx_valid;
  assign rx_header_out    = r_hdr_out;
  assign rx_message_out   = r_msg_out;

`ifdef UART_DEBUG_EN
  assign debug = {r_tx_idx[5:0], r_rx_cnt[3:0], r_tx_state, r_rx_state};
`else
  assign debug = '0;
`endif

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed self-checking bench for uart_ctrl at default parameters (CPB = 33).
module tb_uart_ctrl;

  localparam int CPB = 33;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         ext_tx_valid_in;
  logic         ext_tx_ready_out;
  logic         ext_rx_valid_out;
  logic         ext_rx_ready_in;
  logic [127:0] tx_encrypted_in;
  logic [127:0] tx_decrypted_in;
  logic [31:0]  tx_header_in;
  logic [1:0]   tx_mode_in;
  logic [127:0] rx_message_out;
  logic [31:0]  rx_header_out;
  logic         uart_rx_in;
  logic         uart_tx_out;
  logic [13:0]  debug;

  uart_ctrl dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .ext_tx_valid_in  (ext_tx_valid_in),
    .ext_tx_ready_out (ext_tx_ready_out),
    .ext_rx_valid_out (ext_rx_valid_out),
    .ext_rx_ready_in  (ext_rx_ready_in),
    .tx_encrypted_in  (tx_encrypted_in),
    .tx_decrypted_in  (tx_decrypted_in),
    .tx_header_in     (tx_header_in),
    .tx_mode_in       (tx_mode_in),
    .rx_message_out   (rx_message_out),
    .rx_header_out    (rx_header_out),
    .uart_rx_in       (uart_rx_in),
    .uart_tx_out      (uart_tx_out),
    .debug            (debug)
  );

  always #5 clk_in = ~clk_in;

  int n_asserts = 0;
  int n_fail    = 0;
  int n_pulse   = 0;
  logic [7:0] tx_q[$];

  localparam logic [31:0]  HDR1 = 32'h01020304;
  localparam logic [127:0] MSG1 = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [31:0]  HDR2 = 32'hdeadbeef;
  localparam logic [127:0] MSG2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [31:0]  HDR3 = 32'h0a0b0c0d;
  localparam logic [127:0] MSG3 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
  localparam logic [127:0] DEC  = 128'h55aa55aa123412340000ffff9999cccc;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count receive-valid cycles
  always @(negedge clk_in) if (ext_rx_valid_out === 1'b1) n_pulse++;

  // Serial receiver on uart_tx_out sampling at mid-bit
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk_in);
      if (uart_tx_out === 1'b0 && rst_in === 1'b1) begin
        repeat (CPB / 2) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk_in);
          b[i] = uart_tx_out;
        end
        repeat (CPB) @(negedge clk_in);
        tx_q.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx_in = 1'b0;
    repeat (CPB) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      uart_rx_in = b[i];
      repeat (CPB) @(negedge clk_in);
    end
    uart_rx_in = stop;
    repeat (CPB) @(negedge clk_in);
    uart_rx_in = 1'b1;
  endtask

  task automatic send_packet(input logic [31:0] h, input logic [127:0] m);
    logic [127:0] ms;
    logic [31:0]  hs;
    hs = h;
    ms = m;
    send_byte(8'hBB, 1'b1);
    for (int k = 0; k < 4; k++) begin
      send_byte(hs[7:0], 1'b1);
      hs = hs >> 8;
    end
    for (int k = 0; k < 16; k++) begin
      send_byte(ms[7:0], 1'b1);
      ms = ms >> 8;
    end
  endtask

  // Pulse valid for one capture edge, then measure how long ready stays low
  task automatic run_tx(input string tag, input int exp_cycles);
    int cyc;
    tx_q.delete();
    @(negedge clk_in);
    ext_tx_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    ext_tx_valid_in = 1'b0;
    chk({tag, "_ready_low"}, ext_tx_ready_out, 1'b0);
    chk({tag, "_start_bit"}, uart_tx_out, 1'b0);
    // Inputs changed after capture must be ignored
    tx_header_in    = 32'h0;
    tx_encrypted_in = 128'h0;
    tx_decrypted_in = 128'h0;
    tx_mode_in      = 2'b00;
    cyc = 0;
    while (ext_tx_ready_out !== 1'b1 && cyc < 20000) begin
      @(posedge clk_in);
      #1;
      cyc++;
    end
    chk({tag, "_busy_cycles"}, cyc, exp_cycles);
    repeat (5) @(negedge clk_in);
  endtask

  task automatic chk_tx_bytes(input string tag, input logic [31:0] h, input logic [127:0] b0,
                              input logic [127:0] b1, input int nbody);
    logic [7:0] exp_b[$];
    logic [31:0]  hs;
    logic [127:0] s0, s1;
    hs = h;
    s0 = b0;
    s1 = b1;
    exp_b.push_back(8'hBB);
    for (int k = 0; k < 4; k++) begin exp_b.push_back(hs[7:0]); hs = hs >> 8; end
    for (int k = 0; k < 16; k++) begin exp_b.push_back(s0[7:0]); s0 = s0 >> 8; end
    if (nbody == 2)
      for (int k = 0; k < 16; k++) begin exp_b.push_back(s1[7:0]); s1 = s1 >> 8; end
    chk({tag, "_byte_count"}, tx_q.size(), exp_b.size());
    for (int k = 0; k < exp_b.size() && k < tx_q.size(); k++)
      chk($sformatf("%s_byte%0d", tag, k), tx_q[k], exp_b[k]);
  endtask

  initial begin
    int base;
    rst_in          = 1'b0;
    uart_rx_in      = 1'b1;
    ext_rx_ready_in = 1'b1;
    ext_tx_valid_in = 1'b0;
    tx_encrypted_in = '0;
    tx_decrypted_in = '0;
    tx_header_in    = '0;
    tx_mode_in      = 2'b00;
    repeat (5) @(negedge clk_in);

    // Reset state
    chk("rst_tx_line", uart_tx_out, 1'b1);
    chk("rst_rx_valid", ext_rx_valid_out, 1'b0);
    chk("rst_rx_header", rx_header_out, 32'h0);
    chk("rst_rx_message", rx_message_out, 128'h0);
    chk("rst_debug", debug, 14'h0);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("rst_tx_ready", ext_tx_ready_out, 1'b1);

    // Junk zeros then a packet
    for (int i = 0; i < 40; i++) send_byte(8'h00, 1'b1);
    send_packet(HDR1, MSG1);
    repeat (10) @(negedge clk_in);
    chk("pkt1_header", rx_header_out, HDR1);
    chk("pkt1_message", rx_message_out, MSG1);
    chk("pkt1_pulses", n_pulse, 1);

    // Delivery held off by ready
    ext_rx_ready_in = 1'b0;
    base = n_pulse;
    send_packet(HDR2, MSG2);
    repeat (1000) @(negedge clk_in);
    chk("hold_no_pulse", n_pulse, base);
    ext_rx_ready_in = 1'b1;
    @(negedge clk_in);
    chk("hold_valid_after_ready", ext_rx_valid_out, 1'b1);
    @(negedge clk_in);
    chk("hold_valid_one_cycle", ext_rx_valid_out, 1'b0);
    chk("hold_pulses", n_pulse, base + 1);
    chk("pkt2_header", rx_header_out, HDR2);
    chk("pkt2_message", rx_message_out, MSG2);

    // Framing error in header drops the packet
    base = n_pulse;
    send_byte(8'hBB, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h03, 1'b0);
    repeat (3 * CPB) @(negedge clk_in);
    chk("ferr_no_pulse", n_pulse, base);
    chk("ferr_header_kept", rx_header_out, HDR2);
    send_packet(HDR3, MSG3);
    repeat (10) @(negedge clk_in);
    chk("ferr_next_header", rx_header_out, HDR3);
    chk("ferr_next_message", rx_message_out, MSG3);
    chk("ferr_next_pulses", n_pulse, base + 1);

    // Loopback, mode 01: encrypted body only
    tx_header_in    = rx_header_out;
    tx_encrypted_in = rx_message_out;
    tx_decrypted_in = DEC;
    tx_mode_in      = 2'b01;
    run_tx("tx01", 21 * 10 * CPB);
    chk_tx_bytes("tx01", HDR3, MSG3, DEC, 1);

    // Mode 10: encrypted then decrypted
    tx_header_in    = HDR1;
    tx_encrypted_in = MSG1;
    tx_decrypted_in = DEC;
    tx_mode_in      = 2'b10;
    run_tx("tx10", 37 * 10 * CPB);
    chk_tx_bytes("tx10", HDR1, MSG1, DEC, 2);
    chk("debug_idle", debug, 14'h0);

    // Reset during the start bit of a TX byte
    tx_header_in    = HDR2;
    tx_decrypted_in = DEC;
    tx_mode_in      = 2'b00;
    @(negedge clk_in);
    ext_tx_valid_in = 1'b1;
    @(negedge clk_in);
    ext_tx_valid_in = 1'b0;
    repeat (10) @(negedge clk_in);
    chk("midtx_line_low", uart_tx_out, 1'b0);
    rst_in = 1'b0;
    #1;
    chk("midtx_rst_line_high", uart_tx_out, 1'b1);
    chk("midtx_rst_valid", ext_rx_valid_out, 1'b0);
    chk("midtx_rst_header", rx_header_out, 32'h0);
    chk("midtx_rst_message", rx_message_out, 128'h0);
    chk("midtx_rst_debug", debug, 14'h0);
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("midtx_ready_after", ext_tx_ready_out, 1'b1);
    chk("midtx_line_after", uart_tx_out, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
